riscv_fetch_ctrl: RTL and testbench

Fetch-stage controller that sequences the `riscv_pc` register and the instruction-memory port. It drives `riscv_pc`'s next-PC and stall inputs, issues one instruction-memory request at a time, and buffers each returned instruction in a one-entry slot for decode. Branch and trap redirects are applied immediately to the PC; any fetch response still in flight for a stale address is discarded.

---
 rtl/riscv_pkg.sv | 20 ++
 rtl/riscv_fetch_slot.sv | 50 +++++
 rtl/riscv_fetch_ctrl.sv | 138 +++++++++++++
 tb/tb_riscv_fetch_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg: shared fetch-stage types and constants.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package riscv_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2,
        DROP  = 2'd3
    } fetch_state_t;

    localparam logic [31:0] RISCV_NOP            = 32'h0000_0013;
    localparam logic [63:0] DEFAULT_RESET_VECTOR = 64'h0;

endpackage

`default_nettype wire

// File: rtl/riscv_fetch_slot.sv
// ---------------------------------------------------------------------------
// riscv_fetch_slot: one-entry instruction buffer between fetch and decode.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module riscv_fetch_slot
    import riscv_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             consume_i,
    input  logic             flush_i,
    input  logic [31:0]      instr_i,
    input  logic [WIDTH-1:0] pc_i,
    output logic [31:0]      instr_o,
    output logic [WIDTH-1:0] pc_o,
    output logic             valid_o
);

    logic [31:0]      instr_q;
    logic [WIDTH-1:0] pc_q;
    logic             valid_q;

    // A load in the same cycle as a consume refills the slot; flush wins over both.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            instr_q <= RISCV_NOP;
            pc_q    <= '0;
            valid_q <= 1'b0;
        end else if (flush_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            instr_q <= instr_i;
            pc_q    <= pc_i;
            valid_q <= 1'b1;
        end else if (consume_i) begin
            valid_q <= 1'b0;
        end
    end

    assign instr_o = instr_q;
    assign pc_o    = pc_q;
    assign valid_o = valid_q;

endmodule

`default_nettype wire

// File: rtl/riscv_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// riscv_fetch_ctrl: sequences the PC register and imem port, one request at a time.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module riscv_fetch_ctrl
    import riscv_pkg::*;
#(
    parameter int               WIDTH        = 64,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEFAULT_RESET_VECTOR)
) (
    input  logic             i_riscv_fctl_clk,
    input  logic             i_riscv_fctl_rst,
    input  logic [WIDTH-1:0] i_riscv_fctl_pc,
    output logic [WIDTH-1:0] o_riscv_fctl_nextpc,
    output logic             o_riscv_fctl_stallpc,
    output logic             o_riscv_fctl_imem_req,
    output logic [WIDTH-1:0] o_riscv_fctl_imem_addr,
    input  logic             i_riscv_fctl_imem_ack,
    input  logic [31:0]      i_riscv_fctl_imem_rdata,
    input  logic             i_riscv_fctl_id_stall,
    output logic [31:0]      o_riscv_fctl_instr,
    output logic [WIDTH-1:0] o_riscv_fctl_instr_pc,
    output logic             o_riscv_fctl_instr_valid,
    input  logic             i_riscv_fctl_branch_taken,
    input  logic [WIDTH-1:0] i_riscv_fctl_branch_target,
    input  logic             i_riscv_fctl_trap,
    input  logic [WIDTH-1:0] i_riscv_fctl_trap_vector
);

    fetch_state_t     state_q, state_d;
    logic [WIDTH-1:0] req_addr_q, req_addr_d;

    logic             redirect;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] pc_plus4;
    logic             slot_free;
    logic             slot_consume;
    logic             slot_load;
    logic             slot_flush;
    logic [WIDTH-1:0] load_pc;

    assign redirect     = i_riscv_fctl_trap | i_riscv_fctl_branch_taken;
    assign target       = (i_riscv_fctl_trap ? i_riscv_fctl_trap_vector : i_riscv_fctl_branch_target)
                          & ~{{(WIDTH-2){1'b0}}, 2'b11};
    assign pc_plus4     = i_riscv_fctl_pc + WIDTH'(4);
    assign slot_free    = !o_riscv_fctl_instr_valid | !i_riscv_fctl_id_stall;
    assign slot_consume = o_riscv_fctl_instr_valid & !i_riscv_fctl_id_stall;

    always_comb begin
        state_d                = state_q;
        req_addr_d             = req_addr_q;
        o_riscv_fctl_stallpc   = 1'b1;
        o_riscv_fctl_nextpc    = pc_plus4;
        o_riscv_fctl_imem_req  = 1'b0;
        o_riscv_fctl_imem_addr = i_riscv_fctl_pc;
        slot_load              = 1'b0;
        slot_flush             = 1'b0;
        load_pc                = i_riscv_fctl_pc;

        // Reset drops the request immediately so imem can abandon it in the same cycle.
        if (i_riscv_fctl_rst) begin
            o_riscv_fctl_nextpc    = RESET_VECTOR;
            o_riscv_fctl_imem_addr = '0;
        end else begin
            unique case (state_q)
                BOOT: begin
                    o_riscv_fctl_stallpc = 1'b0;
                    o_riscv_fctl_nextpc  = RESET_VECTOR;
                    state_d              = FETCH;
                end
                FETCH: begin
                    if (redirect) begin
                        o_riscv_fctl_stallpc = 1'b0;
                        o_riscv_fctl_nextpc  = target;
                        slot_flush           = 1'b1;
                    end else if (slot_free) begin
                        o_riscv_fctl_imem_req = 1'b1;
                        if (i_riscv_fctl_imem_ack) begin
                            slot_load            = 1'b1;
                            o_riscv_fctl_stallpc = 1'b0;
                        end else begin
                            req_addr_d = i_riscv_fctl_pc;
                            state_d    = WAIT;
                        end
                    end
                end
                WAIT, DROP: begin
                    o_riscv_fctl_imem_req  = 1'b1;
                    o_riscv_fctl_imem_addr = req_addr_q;
                    load_pc                = req_addr_q;
                    if (redirect) begin
                        o_riscv_fctl_stallpc = 1'b0;
                        o_riscv_fctl_nextpc  = target;
                        slot_flush           = 1'b1;
                        state_d              = i_riscv_fctl_imem_ack ? FETCH : DROP;
                    end else if (i_riscv_fctl_imem_ack) begin
                        state_d = FETCH;
                        if (state_q == WAIT) begin
                            slot_load            = 1'b1;
                            o_riscv_fctl_stallpc = 1'b0;
                        end
                    end
                end
                default: state_d = BOOT;
            endcase
        end
    end

    always_ff @(posedge i_riscv_fctl_clk) begin
        if (i_riscv_fctl_rst) begin
            state_q    <= BOOT;
            req_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            req_addr_q <= req_addr_d;
        end
    end

    riscv_fetch_slot #(
        .WIDTH (WIDTH)
    ) u_slot (
        .clk_i     (i_riscv_fctl_clk),
        .rst_i     (i_riscv_fctl_rst),
        .load_i    (slot_load),
        .consume_i (slot_consume),
        .flush_i   (slot_flush),
        .instr_i   (i_riscv_fctl_imem_rdata),
        .pc_i      (load_pc),
        .instr_o   (o_riscv_fctl_instr),
        .pc_o      (o_riscv_fctl_instr_pc),
        .valid_o   (o_riscv_fctl_instr_valid)
    );

endmodule

`default_nettype wire

// File: tb/tb_riscv_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_riscv_fetch_ctrl: directed stimulus with a scoreboard of decoded instructions.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_riscv_fetch_ctrl;

    localparam int          WIDTH = 64;
    localparam logic [63:0] RV    = 64'h8000_0000;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] pc;
    logic [63:0] nextpc;
    logic        stallpc;
    logic        req;
    logic [63:0] addr;
    logic        ack;
    logic [31:0] rdata;
    logic        id_stall;
    logic [31:0] instr;
    logic [63:0] instr_pc;
    logic        valid;
    logic        br;
    logic [63:0] bt;
    logic        trap;
    logic [63:0] tv;

    int lat;
    int cnt;
    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
    } exp_t;
    exp_t exp_q[$];

    logic        prev_pend;
    logic [63:0] prev_addr;

    always #5 clk = ~clk;

    riscv_fetch_ctrl #(
        .WIDTH        (WIDTH),
        .RESET_VECTOR (RV)
    ) dut (
        .i_riscv_fctl_clk           (clk),
        .i_riscv_fctl_rst           (rst),
        .i_riscv_fctl_pc            (pc),
        .o_riscv_fctl_nextpc        (nextpc),
        .o_riscv_fctl_stallpc       (stallpc),
        .o_riscv_fctl_imem_req      (req),
        .o_riscv_fctl_imem_addr     (addr),
        .i_riscv_fctl_imem_ack      (ack),
        .i_riscv_fctl_imem_rdata    (rdata),
        .i_riscv_fctl_id_stall      (id_stall),
        .o_riscv_fctl_instr         (instr),
        .o_riscv_fctl_instr_pc      (instr_pc),
        .o_riscv_fctl_instr_valid   (valid),
        .i_riscv_fctl_branch_taken  (br),
        .i_riscv_fctl_branch_target (bt),
        .i_riscv_fctl_trap          (trap),
        .i_riscv_fctl_trap_vector   (tv)
    );

    // Instruction memory: word content is a fixed function of its address.
    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ 32'h0000_0033;
    endfunction

    assign ack   = req && !rst && (cnt >= lat);
    assign rdata = mem_word(addr);

    always @(posedge clk) begin
        if (rst || !req || ack) cnt <= 0;
        else                    cnt <= cnt + 1;
    end

    // PC register as the controller sees it.
    always @(posedge clk) begin
        if (rst)          pc <= 64'h0;
        else if (!stallpc) pc <= nextpc;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic push(input logic [63:0] a);
        exp_t e;
        e.pc    = a;
        e.instr = mem_word(a);
        exp_q.push_back(e);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Monitor: each consumed slot entry is checked against the scoreboard, and
    // an outstanding request must keep req high with a stable address.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_pend <= 1'b0;
        end else begin
            if (prev_pend) begin
                chk("req_held", {63'h0, req}, 64'h1);
                chk("addr_stable", addr, prev_addr);
            end
            if (valid && !id_stall) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL sb_unexpected: got instr_pc %h instr %h, expected no entry", instr_pc, instr);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_pc", instr_pc, e.pc);
                    chk("sb_instr", {32'h0, instr}, {32'h0, e.instr});
                end
            end
            prev_pend <= req && !ack;
            prev_addr <= addr;
        end
    end

    initial begin
        rst = 1'b1; id_stall = 1'b0; br = 1'b0; bt = '0; trap = 1'b0; tv = '0; lat = 0;
        tick; tick;
        @(negedge clk);
        chk("rst_stallpc", {63'h0, stallpc}, 64'h1);
        chk("rst_nextpc", nextpc, RV);
        chk("rst_req", {63'h0, req}, 64'h0);
        chk("rst_addr", addr, 64'h0);
        chk("rst_instr", {32'h0, instr}, {32'h0, NOP});
        chk("rst_instr_pc", instr_pc, 64'h0);
        chk("rst_valid", {63'h0, valid}, 64'h0);

        // BOOT
        tick; rst = 1'b0;
        @(negedge clk);
        chk("boot_req", {63'h0, req}, 64'h0);
        chk("boot_stallpc", {63'h0, stallpc}, 64'h0);
        chk("boot_nextpc", nextpc, RV);
        push(RV); push(RV + 4); push(RV + 8);

        // Zero-wait streaming
        tick; @(negedge clk);
        chk("f0_req", {63'h0, req}, 64'h1);
        chk("f0_addr", addr, RV);
        chk("f0_stallpc", {63'h0, stallpc}, 64'h0);
        chk("f0_nextpc", nextpc, RV + 4);
        tick; @(negedge clk);
        chk("f1_stallpc", {63'h0, stallpc}, 64'h0);
        chk("f1_pc", pc, RV + 4);
        tick; @(negedge clk);
        chk("f2_stallpc", {63'h0, stallpc}, 64'h0);

        // Decode stall holds everything for 5 cycles
        tick; id_stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick;
            @(negedge clk);
            chk("stall_req", {63'h0, req}, 64'h0);
            chk("stall_pc", pc, RV + 12);
            chk("stall_instr_pc", instr_pc, RV + 8);
            chk("stall_valid", {63'h0, valid}, 64'h1);
        end
        tick; id_stall = 1'b0;
        @(negedge clk);
        chk("release_req", {63'h0, req}, 64'h1);
        chk("release_addr", addr, RV + 12);

        // Branch to 0x1000, then a 3-cycle imem
        tick; id_stall = 1'b1; br = 1'b1; bt = 64'h1000; lat = 3;
        @(negedge clk);
        chk("br_stallpc", {63'h0, stallpc}, 64'h0);
        chk("br_nextpc", nextpc, 64'h1000);
        chk("br_req", {63'h0, req}, 64'h0);
        tick; br = 1'b0; id_stall = 1'b0;
        push(64'h1000);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick;
            @(negedge clk);
            if (i == 0) chk("br_flush_valid", {63'h0, valid}, 64'h0);
            chk("wait_req", {63'h0, req}, 64'h1);
            chk("wait_addr", addr, 64'h1000);
            chk("wait_pc", pc, 64'h1000);
            chk("wait_stallpc", {63'h0, stallpc}, (i == 3) ? 64'h0 : 64'h1);
        end
        tick; @(negedge clk);
        chk("after_ack_pc", pc, 64'h1004);

        // Branch to 0x2002 while waiting on 0x1004
        tick; br = 1'b1; bt = 64'h2002;
        @(negedge clk);
        chk("drop_nextpc", nextpc, 64'h2000);
        chk("drop_stallpc", {63'h0, stallpc}, 64'h0);
        tick; br = 1'b0;
        @(negedge clk);
        chk("drop_pc", pc, 64'h2000);
        chk("drop_addr", addr, 64'h1004);
        chk("drop_hold", {63'h0, stallpc}, 64'h1);
        tick; @(negedge clk);
        chk("stale_valid", {63'h0, valid}, 64'h0);
        tick; lat = 0; push(64'h2000);
        @(negedge clk);
        chk("stale_valid2", {63'h0, valid}, 64'h0);
        chk("retarget_req", {63'h0, req}, 64'h1);
        chk("retarget_addr", addr, 64'h2000);
        tick;

        // Trap and branch together: trap wins
        tick; id_stall = 1'b1; trap = 1'b1; tv = 64'h100; br = 1'b1; bt = 64'h200;
        @(negedge clk);
        chk("trap_nextpc", nextpc, 64'h100);
        chk("trap_stallpc", {63'h0, stallpc}, 64'h0);
        tick; trap = 1'b0; br = 1'b0; lat = 5;
        @(negedge clk);
        chk("trap_pc", pc, 64'h100);
        chk("trap_flush", {63'h0, valid}, 64'h0);

        // Reset while waiting
        tick; rst = 1'b1;
        @(negedge clk);
        chk("mrst_req", {63'h0, req}, 64'h0);
        chk("mrst_stallpc", {63'h0, stallpc}, 64'h1);
        chk("mrst_nextpc", nextpc, RV);
        chk("mrst_addr", addr, 64'h0);
        tick; rst = 1'b0; id_stall = 1'b0; lat = 0;
        @(negedge clk);
        chk("mrst_valid", {63'h0, valid}, 64'h0);
        chk("mrst_instr", {32'h0, instr}, {32'h0, NOP});
        chk("mrst_instr_pc", instr_pc, 64'h0);
        chk("mrst_boot_req", {63'h0, req}, 64'h0);
        push(RV); push(RV + 4);
        tick; @(negedge clk);
        chk("restart_addr", addr, RV);
        tick; tick; tick; id_stall = 1'b1;
        @(negedge clk);
        chk("restart_hold_pc", instr_pc, RV + 8);

        // PC wrap at the top of the address space
        tick; br = 1'b1; bt = 64'hFFFF_FFFF_FFFF_FFFC;
        tick; br = 1'b0;
        @(negedge clk);
        chk("wrap_addr", addr, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("wrap_nextpc", nextpc, 64'h0);
        tick; @(negedge clk);
        chk("wrap_pc", pc, 64'h0);
        chk("wrap_instr_pc", instr_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("wrap_instr", {32'h0, instr}, 64'h0000_0000_FFFF_FFCF);

        tick; tick;
        chk("sb_drained", 64'(exp_q.size()), 64'h0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
